// File: rtl/sdio_data_block_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sdio_data_block_ctrl
// Description : Transfer sequencer in front of sdio_data_phy. Takes one
//               CMD53-style transfer (byte or block mode) and splits it into
//               per-block phy activations. Host-bound read data is staged
//               whole in a FIFO before the phy is told the data is ready.
//               Card-bound write data is forwarded to the function. Reports
//               CRC, abort and timeout status.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : FIFO_AW        log2 of read-staging FIFO depth (bytes)
//               TIMEOUT_CYCLES phy-finish watchdog limit in clk cycles
// Macro       : SDIO_DATA_TIMEOUT_EN - enables the phy-finish watchdog;
//               when undefined o_timeout is tied 0 and waits are unbounded.
// Ports       : clk/rst            clock, synchronous active-high reset
//               i_xfer_*/i_block_* transfer request fields (latched on start)
//               i_abort            stop at the next block boundary
//               o_busy/o_xfer_*    transfer status and completion strobes
//               o_crc_err/o_timeout sticky status until the next start
//               o_blocks_done      completed blocks in this transfer
//               o_func_*/i_func_*  function-side write and read byte paths
//               o_phy_*/i_phy_*    control and data to/from sdio_data_phy
// ============================================================================
module sdio_data_block_ctrl #(
  parameter int          FIFO_AW        = 9,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_xfer_start,
  input  logic        i_xfer_write,
  input  logic        i_block_mode,
  input  logic [12:0] i_block_size,
  input  logic [12:0] i_byte_count,
  input  logic [8:0]  i_block_count,
  input  logic        i_abort,
  output logic        o_busy,
  output logic        o_xfer_done,
  output logic        o_xfer_err,
  output logic        o_crc_err,
  output logic        o_timeout,
  output logic [8:0]  o_blocks_done,
  output logic        o_func_wr_stb,
  output logic [7:0]  o_func_wr_data,
  output logic        o_func_rd_req,
  input  logic        i_func_rd_stb,
  input  logic [7:0]  i_func_rd_data,
  output logic        o_phy_activate,
  output logic        o_phy_write_flag,
  output logic [12:0] o_phy_data_count,
  input  logic        i_phy_finished,
  input  logic        i_phy_wr_stb,
  input  logic [7:0]  i_phy_wr_data,
  output logic        o_phy_rd_stb,
  output logic [7:0]  o_phy_rd_data,
  input  logic        i_phy_hst_rdy,
  output logic        o_phy_com_rdy,
  input  logic        i_phy_crc_good
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_ACTIVATE = 3'd2,
    S_XFER     = 3'd3,
    S_WAIT_FIN = 3'd4,
    S_RELEASE  = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  localparam logic [13:0]      c_depth_len = 14'(1 << FIFO_AW);
  localparam logic [FIFO_AW:0] c_fifo_full = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0] c_fcnt_one  = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW-1:0] c_ptr_one = {{(FIFO_AW-1){1'b0}}, 1'b1};

  state_t r_state, w_next;

  // Latched transfer fields
  logic        r_write;
  logic        r_block_mode;
  logic [12:0] r_len;
  logic [8:0]  r_block_count;

  logic        r_err;
  logic        r_crc_err;
  logic [8:0]  r_blocks_done;

  // Per-block progress: bytes fetched from the function, and bytes moved
  // through the phy (read pops or accepted write strobes).
  logic [12:0] r_fetch;
  logic [12:0] r_xcnt;
  logic        r_burst;

  // Read-staging FIFO
  logic [7:0]         r_mem [0:(1<<FIFO_AW)-1];
  logic [FIFO_AW-1:0] r_wptr, r_rptr;
  logic [FIFO_AW:0]   r_fcnt;

  logic       r_rd_stb;
  logic [7:0] r_rd_data;
  logic       r_func_wr_stb;
  logic [7:0] r_func_wr_data;

  logic        w_accept, w_active, w_len_ok, w_push, w_pop, w_wr_acc, w_last;
  logic        w_set_err, w_set_crc, w_tmo_hit;
  logic [12:0] w_start_len;

  assign w_accept    = (r_state == S_IDLE) && i_xfer_start;
  assign w_start_len = i_block_mode ? i_block_size :
                       ((i_byte_count == 13'd0) ? 13'd512 : i_byte_count);
  assign w_active    = (r_state inside {S_ACTIVATE, S_XFER, S_WAIT_FIN});
  assign w_len_ok    = ({1'b0, r_len} <= c_depth_len);

  assign o_func_rd_req = (r_state == S_LOAD) && w_len_ok &&
                         (r_fetch != r_len) && (r_fcnt != c_fifo_full);
  assign w_push = o_func_rd_req && i_func_rd_stb;

  // Once hst_rdy opens the burst it keeps popping every cycle until the
  // whole block is out, independent of hst_rdy afterwards.
  assign w_pop = (r_state == S_XFER) && !r_write && (r_xcnt != r_len) &&
                 (r_burst || i_phy_hst_rdy);

  // Write strobes beyond the block length are dropped.
  assign w_wr_acc = w_active && r_write && i_phy_wr_stb && (r_xcnt != r_len);

  // Block count 0 means unbounded; only abort or an error ends it.
  assign w_last = !r_block_mode ||
                  ((r_block_count != 9'd0) && ((r_blocks_done + 9'd1) == r_block_count));

`ifdef SDIO_DATA_TIMEOUT_EN
  logic [23:0] r_tmo_cnt;
  logic        r_timeout;

  assign w_tmo_hit = w_active && (r_tmo_cnt == (TIMEOUT_CYCLES - 24'd1));

  // Counts only while the phy is engaged, so it restarts for every block.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_cnt <= 24'd0;
      r_timeout <= 1'b0;
    end else begin
      if (w_active && !w_tmo_hit) r_tmo_cnt <= r_tmo_cnt + 24'd1;
      else                        r_tmo_cnt <= 24'd0;
      if (w_accept)  r_timeout <= 1'b0;
      if (w_tmo_hit) r_timeout <= 1'b1;
    end
  end
  assign o_timeout = r_timeout;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT_CYCLES;
  assign w_tmo_hit    = 1'b0;
  assign o_timeout    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next    = r_state;
    w_set_err = 1'b0;
    w_set_crc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_xfer_start) begin
          if (i_block_mode && (i_block_size == 13'd0)) begin
            w_next    = S_DONE;
            w_set_err = 1'b1;
          end else if (i_xfer_write) begin
            w_next = S_ACTIVATE;
          end else begin
            w_next = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (!w_len_ok) begin
          w_next    = S_DONE;
          w_set_err = 1'b1;
        end else if (r_fetch == r_len) begin
          w_next = S_ACTIVATE;
        end
      end
      S_ACTIVATE: w_next = S_XFER;
      S_XFER: begin
        if ((r_xcnt == r_len) || i_phy_finished) w_next = S_WAIT_FIN;
      end
      S_WAIT_FIN: begin
        if (i_phy_finished) begin
          if (r_write && !i_phy_crc_good) begin
            w_next    = S_DONE;
            w_set_err = 1'b1;
            w_set_crc = 1'b1;
          end else begin
            w_next = S_RELEASE;
          end
        end
      end
      S_RELEASE: begin
        if (!i_phy_finished) begin
          if (w_last || i_abort) w_next = S_DONE;
          else if (r_write)      w_next = S_ACTIVATE;
          else                   w_next = S_LOAD;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_tmo_hit) begin
      w_next    = S_DONE;
      w_set_err = 1'b1;
    end
  end

  // Datapath and status
  always_ff @(posedge clk) begin
    if (rst) begin
      r_write        <= 1'b0;
      r_block_mode   <= 1'b0;
      r_len          <= 13'd0;
      r_block_count  <= 9'd0;
      r_err          <= 1'b0;
      r_crc_err      <= 1'b0;
      r_blocks_done  <= 9'd0;
      r_fetch        <= 13'd0;
      r_xcnt         <= 13'd0;
      r_burst        <= 1'b0;
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_fcnt         <= '0;
      r_rd_stb       <= 1'b0;
      r_rd_data      <= 8'h00;
      r_func_wr_stb  <= 1'b0;
      r_func_wr_data <= 8'h00;
    end else begin
      r_rd_stb       <= w_pop;
      r_rd_data      <= w_pop ? r_mem[r_rptr] : 8'h00;
      r_func_wr_stb  <= w_wr_acc;
      r_func_wr_data <= w_wr_acc ? i_phy_wr_data : 8'h00;

      if (w_accept) begin
        r_write       <= i_xfer_write;
        r_block_mode  <= i_block_mode;
        r_len         <= w_start_len;
        r_block_count <= i_block_count;
        r_err         <= 1'b0;
        r_crc_err     <= 1'b0;
        r_blocks_done <= 9'd0;
      end
      if (w_set_err) r_err     <= 1'b1;
      if (w_set_crc) r_crc_err <= 1'b1;

      if (w_push) begin
        r_wptr  <= r_wptr + c_ptr_one;
        r_fcnt  <= r_fcnt + c_fcnt_one;
        r_fetch <= r_fetch + 13'd1;
      end
      if (w_pop) begin
        r_rptr  <= r_rptr + c_ptr_one;
        r_fcnt  <= r_fcnt - c_fcnt_one;
        r_xcnt  <= r_xcnt + 13'd1;
        r_burst <= 1'b1;
      end
      if (w_wr_acc) r_xcnt <= r_xcnt + 13'd1;

      if ((r_state == S_RELEASE) && !i_phy_finished)
        r_blocks_done <= r_blocks_done + 9'd1;

      // Between blocks and outside transfers the per-block counters and the
      // FIFO are returned to empty.
      if (r_state inside {S_IDLE, S_RELEASE, S_DONE}) begin
        r_fetch <= 13'd0;
        r_xcnt  <= 13'd0;
        r_burst <= 1'b0;
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_fcnt  <= '0;
      end
    end
  end

  // FIFO storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_func_rd_data;
  end

  assign o_busy           = !(r_state inside {S_IDLE, S_DONE});
  assign o_xfer_done      = (r_state == S_DONE);
  assign o_xfer_err       = (r_state == S_DONE) && r_err;
  assign o_crc_err        = r_crc_err;
  assign o_blocks_done    = r_blocks_done;
  assign o_func_wr_stb    = r_func_wr_stb;
  assign o_func_wr_data   = r_func_wr_data;
  assign o_phy_activate   = w_active;
  assign o_phy_write_flag = w_active && r_write;
  assign o_phy_data_count = r_len;
  assign o_phy_rd_stb     = r_rd_stb;
  assign o_phy_rd_data    = r_rd_data;
  // Read data is fully staged before ACTIVATE; ready stays up through the burst.
  assign o_phy_com_rdy    = !r_write && (r_state inside {S_ACTIVATE, S_XFER});

endmodule
`default_nettype wire

// File: tb/tb_sdio_data_block_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdio_data_block_ctrl
// Description : Directed self-checking bench for sdio_data_block_ctrl. Acts
//               as command layer, function and phy in one linear sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdio_data_block_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_xfer_start = 1'b0, i_xfer_write = 1'b0, i_block_mode = 1'b0;
  logic [12:0] i_block_size = 13'd0, i_byte_count = 13'd0;
  logic [8:0]  i_block_count = 9'd0;
  logic        i_abort = 1'b0;
  logic        o_busy, o_xfer_done, o_xfer_err, o_crc_err, o_timeout;
  logic [8:0]  o_blocks_done;
  logic        o_func_wr_stb;
  logic [7:0]  o_func_wr_data;
  logic        o_func_rd_req;
  logic        i_func_rd_stb = 1'b0;
  logic [7:0]  i_func_rd_data = 8'h00;
  logic        o_phy_activate, o_phy_write_flag;
  logic [12:0] o_phy_data_count;
  logic        i_phy_finished = 1'b0, i_phy_wr_stb = 1'b0;
  logic [7:0]  i_phy_wr_data = 8'h00;
  logic        o_phy_rd_stb;
  logic [7:0]  o_phy_rd_data;
  logic        i_phy_hst_rdy = 1'b0;
  logic        o_phy_com_rdy;
  logic        i_phy_crc_good = 1'b1;

  sdio_data_block_ctrl #(.FIFO_AW(9), .TIMEOUT_CYCLES(24'd100)) dut (
    .clk(clk), .rst(rst),
    .i_xfer_start(i_xfer_start), .i_xfer_write(i_xfer_write),
    .i_block_mode(i_block_mode), .i_block_size(i_block_size),
    .i_byte_count(i_byte_count), .i_block_count(i_block_count),
    .i_abort(i_abort), .o_busy(o_busy), .o_xfer_done(o_xfer_done),
    .o_xfer_err(o_xfer_err), .o_crc_err(o_crc_err), .o_timeout(o_timeout),
    .o_blocks_done(o_blocks_done), .o_func_wr_stb(o_func_wr_stb),
    .o_func_wr_data(o_func_wr_data), .o_func_rd_req(o_func_rd_req),
    .i_func_rd_stb(i_func_rd_stb), .i_func_rd_data(i_func_rd_data),
    .o_phy_activate(o_phy_activate), .o_phy_write_flag(o_phy_write_flag),
    .o_phy_data_count(o_phy_data_count), .i_phy_finished(i_phy_finished),
    .i_phy_wr_stb(i_phy_wr_stb), .i_phy_wr_data(i_phy_wr_data),
    .o_phy_rd_stb(o_phy_rd_stb), .o_phy_rd_data(o_phy_rd_data),
    .i_phy_hst_rdy(i_phy_hst_rdy), .o_phy_com_rdy(o_phy_com_rdy),
    .i_phy_crc_good(i_phy_crc_good)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Passive observers on the falling edge
  logic [7:0] rd_bytes [0:255];
  logic [7:0] wr_bytes [0:255];
  int rd_n = 0, wr_n = 0, act_rises = 0, wr_ff = 0;
  logic prev_act = 1'b0;

  always @(negedge clk) begin
    prev_act <= o_phy_activate;
    if (o_phy_activate && !prev_act) act_rises <= act_rises + 1;
    if (o_phy_rd_stb) begin
      if (rd_n < 256) rd_bytes[rd_n] <= o_phy_rd_data;
      rd_n <= rd_n + 1;
    end
    if (o_func_wr_stb) begin
      if (wr_n < 256) wr_bytes[wr_n] <= o_func_wr_data;
      wr_n <= wr_n + 1;
      if (o_func_wr_data == 8'hFF) wr_ff <= wr_ff + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_act(input logic val, input string tag);
    for (int i = 0; i < 300 && o_phy_activate !== val; i++) step();
    check(tag, 32'(o_phy_activate), 32'(val));
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 300 && o_xfer_done !== 1'b1; i++) step();
    check(tag, 32'(o_xfer_done), 32'd1);
  endtask

  task automatic wait_rd(input int target, input string tag);
    for (int i = 0; i < 300 && rd_n < target; i++) step();
    check(tag, 32'(rd_n), 32'(target));
  endtask

  // Function side: answer o_func_rd_req with n bytes base + k*stride.
  task automatic load_block(input int n, input int base, input int stride, input string tag);
    int pushed = 0;
    for (int i = 0; i < 400 && pushed < n; i++) begin
      if (o_func_rd_req) begin
        i_func_rd_stb  = 1'b1;
        i_func_rd_data = 8'(base + pushed * stride);
        pushed++;
      end else begin
        i_func_rd_stb = 1'b0;
      end
      step();
    end
    i_func_rd_stb = 1'b0;
    check(tag, 32'(pushed), 32'(n));
  endtask

  task automatic send_wr(input int n, input int base, input logic extra);
    for (int k = 0; k < n; k++) begin
      i_phy_wr_stb  = 1'b1;
      i_phy_wr_data = 8'(base + k);
      step();
    end
    if (extra) begin
      i_phy_wr_data = 8'hFF;
      step();
    end
    i_phy_wr_stb = 1'b0;
  endtask

  // Phy finish handshake: finished high until activate drops, then low.
  task automatic phy_finish(input logic crc, input string tag);
    i_phy_finished = 1'b1;
    i_phy_crc_good = crc;
    wait_act(1'b0, tag);
    i_phy_finished = 1'b0;
  endtask

  task automatic start_xfer(input logic wr, input logic bm, input int bsize,
                            input int bcnt, input int count);
    i_xfer_start  = 1'b1;
    i_xfer_write  = wr;
    i_block_mode  = bm;
    i_block_size  = 13'(bsize);
    i_byte_count  = 13'(bcnt);
    i_block_count = 9'(count);
    step();
    i_xfer_start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, required completion)");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_rd, base_wr, base_act;

    // ---------------- reset state ----------------
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_busy",      32'(o_busy), 32'd0);
    check("rst_done",      32'(o_xfer_done), 32'd0);
    check("rst_err",       32'(o_xfer_err), 32'd0);
    check("rst_crc",       32'(o_crc_err), 32'd0);
    check("rst_tmo",       32'(o_timeout), 32'd0);
    check("rst_act",       32'(o_phy_activate), 32'd0);
    check("rst_blocks",    32'(o_blocks_done), 32'd0);
    check("rst_rdreq",     32'(o_func_rd_req), 32'd0);
    check("rst_comrdy",    32'(o_phy_com_rdy), 32'd0);
    check("rst_count",     32'(o_phy_data_count), 32'd0);

    // ---------------- 1: byte-mode read of 4 bytes ----------------
    base_rd = rd_n;
    start_xfer(1'b0, 1'b0, 0, 4, 0);
    check("t1_busy", 32'(o_busy), 32'd1);
    check("t1_rdreq", 32'(o_func_rd_req), 32'd1);
    load_block(4, 8'h11, 8'h11, "t1_load");
    check("t1_comrdy_early", 32'(o_phy_com_rdy), 32'd0);
    wait_act(1'b1, "t1_act");
    check("t1_comrdy", 32'(o_phy_com_rdy), 32'd1);
    check("t1_dcount", 32'(o_phy_data_count), 32'd4);
    check("t1_wflag",  32'(o_phy_write_flag), 32'd0);
    i_phy_hst_rdy = 1'b1;
    wait_rd(base_rd + 4, "t1_rdn");
    i_phy_hst_rdy = 1'b0;
    phy_finish(1'b1, "t1_release");
    wait_done("t1_done");
    check("t1_err",    32'(o_xfer_err), 32'd0);
    check("t1_blocks", 32'(o_blocks_done), 32'd1);
    check("t1_b0", 32'(rd_bytes[base_rd + 0]), 32'h11);
    check("t1_b1", 32'(rd_bytes[base_rd + 1]), 32'h22);
    check("t1_b2", 32'(rd_bytes[base_rd + 2]), 32'h33);
    check("t1_b3", 32'(rd_bytes[base_rd + 3]), 32'h44);
    step();
    check("t1_rdn_final", 32'(rd_n - base_rd), 32'd4);
    check("t1_idle_busy", 32'(o_busy), 32'd0);

    // ---------------- 2: block write 3 x 8 ----------------
    base_wr  = wr_n;
    base_act = act_rises;
    start_xfer(1'b1, 1'b1, 8, 0, 3);
    for (int b = 0; b < 3; b++) begin
      wait_act(1'b1, "t2_act");
      check("t2_wflag",  32'(o_phy_write_flag), 32'd1);
      check("t2_dcount", 32'(o_phy_data_count), 32'd8);
      send_wr(8, b * 16, 1'b1);
      phy_finish(1'b1, "t2_release");
    end
    wait_done("t2_done");
    check("t2_err",    32'(o_xfer_err), 32'd0);
    check("t2_crc",    32'(o_crc_err), 32'd0);
    check("t2_blocks", 32'(o_blocks_done), 32'd3);
    step();
    check("t2_wrn",    32'(wr_n - base_wr), 32'd24);
    check("t2_acts",   32'(act_rises - base_act), 32'd3);
    check("t2_first",  32'(wr_bytes[base_wr]), 32'h00);
    check("t2_last",   32'(wr_bytes[base_wr + 23]), 32'h27);
    check("t2_extra",  32'(wr_ff), 32'd0);

    // ---------------- 3: block write, CRC failure on block 1 ----------------
    base_wr = wr_n;
    start_xfer(1'b1, 1'b1, 4, 0, 2);
    wait_act(1'b1, "t3_act");
    send_wr(4, 8'hA0, 1'b0);
    i_phy_finished = 1'b1;
    i_phy_crc_good = 1'b0;
    wait_done("t3_done");
    check("t3_err",    32'(o_xfer_err), 32'd1);
    check("t3_crc",    32'(o_crc_err), 32'd1);
    check("t3_blocks", 32'(o_blocks_done), 32'd0);
    check("t3_act",    32'(o_phy_activate), 32'd0);
    i_phy_finished = 1'b0;
    i_phy_crc_good = 1'b1;
    step();
    step();
    check("t3_crc_sticky", 32'(o_crc_err), 32'd1);
    check("t3_busy",       32'(o_busy), 32'd0);
    check("t3_wrn",        32'(wr_n - base_wr), 32'd4);

    // ---------------- 4: infinite block read, abort in block 3 ----------------
    base_rd = rd_n;
    start_xfer(1'b0, 1'b1, 16, 0, 0);
    check("t4_crc_clr", 32'(o_crc_err), 32'd0);
    for (int b = 0; b < 3; b++) begin
      load_block(16, b * 32, 1, "t4_load");
      wait_act(1'b1, "t4_act");
      check("t4_comrdy", 32'(o_phy_com_rdy), 32'd1);
      i_phy_hst_rdy = 1'b1;
      if (b == 2) begin
        wait_rd(base_rd + 40, "t4_mid");
        i_abort = 1'b1;
      end
      wait_rd(base_rd + 16 * (b + 1), "t4_rdn");
      i_phy_hst_rdy = 1'b0;
      phy_finish(1'b1, "t4_release");
    end
    wait_done("t4_done");
    i_abort = 1'b0;
    check("t4_err",    32'(o_xfer_err), 32'd0);
    check("t4_blocks", 32'(o_blocks_done), 32'd3);
    step();
    check("t4_rdn_final", 32'(rd_n - base_rd), 32'd48);
    check("t4_b3_first",  32'(rd_bytes[base_rd + 32]), 32'h40);
    check("t4_b3_last",   32'(rd_bytes[base_rd + 47]), 32'h4F);

    // ---------------- 5: zero block size, start while busy ----------------
    base_act = act_rises;
    start_xfer(1'b1, 1'b1, 0, 0, 1);
    for (int i = 0; i < 1 && o_xfer_done !== 1'b1; i++) step();
    check("t5_done", 32'(o_xfer_done), 32'd1);
    check("t5_err",  32'(o_xfer_err), 32'd1);
    check("t5_busy", 32'(o_busy), 32'd0);
    step();
    step();
    check("t5_noact", 32'(act_rises - base_act), 32'd0);
    start_xfer(1'b1, 1'b1, 4, 0, 1);
    check("t5b_busy", 32'(o_busy), 32'd1);
    start_xfer(1'b0, 1'b0, 0, 7, 0);
    check("t5b_dcount", 32'(o_phy_data_count), 32'd4);
    check("t5b_wflag",  32'(o_phy_write_flag), 32'd1);
    send_wr(4, 8'h50, 1'b0);
    phy_finish(1'b1, "t5b_release");
    wait_done("t5b_done");
    check("t5b_err",    32'(o_xfer_err), 32'd0);
    check("t5b_blocks", 32'(o_blocks_done), 32'd1);
    step();
    step();
    check("t5b_idle", 32'(o_busy), 32'd0);

    // ---------------- 6: phy never finishes ----------------
    start_xfer(1'b1, 1'b1, 4, 0, 1);
    wait_act(1'b1, "t6_act");
`ifdef SDIO_DATA_TIMEOUT_EN
    repeat (99) step();
    check("t6_act99", 32'(o_phy_activate), 32'd1);
    step();
    check("t6_act100", 32'(o_phy_activate), 32'd0);
    check("t6_tmo",    32'(o_timeout), 32'd1);
    check("t6_done",   32'(o_xfer_done), 32'd1);
    check("t6_err",    32'(o_xfer_err), 32'd1);
`else
    repeat (1000) step();
    check("t6_busy", 32'(o_busy), 32'd1);
    check("t6_act",  32'(o_phy_activate), 32'd1);
    check("t6_tmo",  32'(o_timeout), 32'd0);
`endif
    rst = 1'b1;
    step();
    check("t6_rst_act", 32'(o_phy_activate), 32'd0);
    rst = 1'b0;
    step();
    check("t6_rst_busy",   32'(o_busy), 32'd0);
    check("t6_rst_blocks", 32'(o_blocks_done), 32'd0);
    check("t6_rst_tmo",    32'(o_timeout), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
